// File: rtl/vga_fb_port_arbiter.sv
// +--------------------------------------------------------------------------+
// | vga_fb_port_arbiter: display/host arbiter for a single-port pixel RAM     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module vga_fb_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 6,
  parameter int MAX_STARVE = 8
) (
  input  logic              SYS_CLK,
  input  logic              user_reset_button,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_q,
  output logic [15:0]       host_grants
);

  localparam logic [7:0] c_MAX_STARVE = 8'(MAX_STARVE);

  logic [7:0] r_starve_cnt;
  logic       r_s1_valid;
  logic       r_s1_host;
  logic       r_s2_valid;
  logic       r_s2_host;

  logic w_force;
  logic w_h_gnt;
  logic w_d_gnt;
  logic w_accept;
  logic w_rd_accept;

  // Display wins by default; the host only breaks through once it has starved.
  assign w_force     = h_req & (r_starve_cnt == c_MAX_STARVE);
  assign w_h_gnt     = h_req & (~d_req | w_force);
  assign w_d_gnt     = d_req & ~w_h_gnt;
  assign w_accept    = w_h_gnt | w_d_gnt;
  assign w_rd_accept = w_d_gnt | (w_h_gnt & ~h_we);

  assign h_gnt = w_h_gnt;
  assign d_gnt = w_d_gnt;

  always_ff @(posedge SYS_CLK or posedge user_reset_button) begin
    if (user_reset_button) begin
      r_starve_cnt <= 8'd0;
    end else if (!h_req || w_h_gnt) begin
      r_starve_cnt <= 8'd0;
    end else if (r_starve_cnt != c_MAX_STARVE) begin
      r_starve_cnt <= r_starve_cnt + 8'd1;
    end
  end

  always_ff @(posedge SYS_CLK or posedge user_reset_button) begin
    if (user_reset_button) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
    end else begin
      ram_we <= w_h_gnt & h_we;
      if (w_accept) begin
        ram_addr  <= w_h_gnt ? h_addr : d_addr;
        ram_wdata <= h_wdata;
      end
    end
  end

  // Tag pipeline runs alongside the RAM so ram_q can be steered to its owner.
  always_ff @(posedge SYS_CLK or posedge user_reset_button) begin
    if (user_reset_button) begin
      r_s1_valid <= 1'b0;
      r_s1_host  <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_host  <= 1'b0;
    end else begin
      r_s1_valid <= w_rd_accept;
      r_s1_host  <= w_h_gnt;
      r_s2_valid <= r_s1_valid;
      r_s2_host  <= r_s1_host;
    end
  end

  always_ff @(posedge SYS_CLK or posedge user_reset_button) begin
    if (user_reset_button) begin
      d_rvalid <= 1'b0;
      h_rvalid <= 1'b0;
      d_rdata  <= '0;
      h_rdata  <= '0;
    end else begin
      d_rvalid <= r_s2_valid & ~r_s2_host;
      h_rvalid <= r_s2_valid & r_s2_host;
      if (r_s2_valid && !r_s2_host) begin
        d_rdata <= ram_q;
      end
      if (r_s2_valid && r_s2_host) begin
        h_rdata <= ram_q;
      end
    end
  end

  always_ff @(posedge SYS_CLK or posedge user_reset_button) begin
    if (user_reset_button) begin
      host_grants <= 16'd0;
    end else if (w_h_gnt) begin
      host_grants <= host_grants + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_fb_port_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_vga_fb_port_arbiter: randomized bench with a transaction-level model   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_vga_fb_port_arbiter;

  localparam int AW = 14;
  localparam int DW = 6;
  localparam int MS = 8;

  typedef struct {
    int          due;
    bit          host;
    logic [DW-1:0] data;
  } ret_t;

  logic          SYS_CLK = 1'b0;
  logic          user_reset_button;
  logic          d_req;
  logic [AW-1:0] d_addr;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          h_req;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          h_gnt;
  logic          h_rvalid;
  logic [DW-1:0] h_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_q = '0;
  logic [15:0]   host_grants;

  logic [DW-1:0] mem     [0:(1<<AW)-1] = '{default: '0};
  logic [DW-1:0] ref_mem [0:(1<<AW)-1] = '{default: '0};

  int            n_checks;
  int            n_errors;
  int            m_cyc;
  int            m_starve;
  logic [15:0]   m_hg;
  logic [AW-1:0] m_ram_addr;
  logic          m_ram_we;
  logic [DW-1:0] m_ram_wdata;
  logic [DW-1:0] m_d_rdata;
  logic [DW-1:0] m_h_rdata;
  logic          exp_dg;
  logic          exp_hg;
  logic          obs_dg;
  logic          obs_hg;
  ret_t          q[$];

  always #10 SYS_CLK = ~SYS_CLK;

  // External single-port RAM: one-cycle read latency, old data on a write.
  always @(posedge SYS_CLK) begin
    ram_q <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  vga_fb_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STARVE(MS)) dut (
    .SYS_CLK(SYS_CLK), .user_reset_button(user_reset_button),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_gnt(h_gnt),
    .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_q(ram_q),
    .host_grants(host_grants)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_starve    = 0;
    m_hg        = '0;
    m_ram_addr  = '0;
    m_ram_we    = 1'b0;
    m_ram_wdata = '0;
    m_d_rdata   = '0;
    m_h_rdata   = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_d_rvalid"}, d_rvalid, 0);
    check({tag, "_h_rvalid"}, h_rvalid, 0);
    check({tag, "_d_rdata"}, d_rdata, 0);
    check({tag, "_h_rdata"}, h_rdata, 0);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_ram_we"}, ram_we, 0);
    check({tag, "_ram_wdata"}, ram_wdata, 0);
    check({tag, "_host_grants"}, host_grants, 0);
  endtask

  task automatic set_idle();
    d_req = 1'b0; h_req = 1'b0; h_we = 1'b0;
  endtask

  // One clock: compare at the falling edge, then advance the model on the rising edge.
  task automatic cycle();
    logic dv, hv;
    @(negedge SYS_CLK);
    exp_hg = h_req && (!d_req || m_starve == MS);
    exp_dg = d_req && !exp_hg;
    obs_hg = h_gnt;
    obs_dg = d_gnt;
    check("h_gnt", h_gnt, exp_hg);
    check("d_gnt", d_gnt, exp_dg);
    dv = 1'b0; hv = 1'b0;
    if (q.size() > 0 && q[0].due == m_cyc) begin
      if (q[0].host) begin hv = 1'b1; m_h_rdata = q[0].data; end
      else           begin dv = 1'b1; m_d_rdata = q[0].data; end
      q.delete(0);
    end
    check("d_rvalid", d_rvalid, dv);
    check("h_rvalid", h_rvalid, hv);
    check("d_rdata", d_rdata, m_d_rdata);
    check("h_rdata", h_rdata, m_h_rdata);
    check("rvalid_both", d_rvalid & h_rvalid, 0);
    check("ram_we", ram_we, m_ram_we);
    check("ram_addr", ram_addr, m_ram_addr);
    if (m_ram_we) check("ram_wdata", ram_wdata, m_ram_wdata);
    check("host_grants", host_grants, m_hg);
    @(posedge SYS_CLK);
    m_cyc++;
    if (exp_hg || exp_dg) begin
      m_ram_addr  = exp_hg ? h_addr : d_addr;
      m_ram_wdata = h_wdata;
    end
    m_ram_we = exp_hg && h_we;
    if (exp_hg && h_we)  ref_mem[h_addr] = h_wdata;
    else if (exp_hg)     q.push_back('{m_cyc + 2, 1'b1, ref_mem[h_addr]});
    else if (exp_dg)     q.push_back('{m_cyc + 2, 1'b0, ref_mem[d_addr]});
    if (!h_req || exp_hg)  m_starve = 0;
    else if (m_starve < MS) m_starve++;
    if (exp_hg) m_hg++;
    #1;
  endtask

  task automatic reset_pulse();
    set_idle();
    #1 user_reset_button = 1'b1;
    #1 check_reset_outputs("rst_mid");
    check("rst_d_gnt", d_gnt, 0);
    #1 user_reset_button = 1'b0;
    model_reset();
  endtask

  // Both ports request continuously; the host must break through every MS+1 cycles.
  task automatic prio_run(input int reps);
    int run;
    run = 0;
    d_req = 1'b1; h_req = 1'b1; h_we = 1'b0;
    d_addr = AW'(14'h100 + $urandom_range(0, 7));
    h_addr = AW'(14'h100 + $urandom_range(0, 7));
    for (int i = 0; i < reps * (MS + 1); i++) begin
      cycle();
      if (obs_dg) begin
        run++;
        d_addr = AW'(14'h100 + $urandom_range(0, 7));
      end else if (obs_hg) begin
        check("starve_gap", run, MS);
        run = 0;
        h_addr = AW'(14'h100 + $urandom_range(0, 7));
      end
    end
    set_idle();
    repeat (3) cycle();
  endtask

  initial begin
    n_checks = 0; n_errors = 0; m_cyc = 0;
    user_reset_button = 1'b1;
    set_idle();
    d_addr = '0; h_addr = '0; h_wdata = '0;
    model_reset();
    repeat (3) @(posedge SYS_CLK);
    #1;
    check_reset_outputs("rst_init");
    user_reset_button = 1'b0;

    // Host write then read back with the display idle.
    h_req = 1'b1; h_we = 1'b1; h_addr = 14'h0105; h_wdata = 6'h2A;
    cycle();
    h_we = 1'b0;
    cycle();
    set_idle();
    repeat (3) cycle();
    check("hg_two", host_grants, 2);
    check("h_rdata_2a", h_rdata, 6'h2A);

    // Preload a small window, then run display-priority / routing traffic over it.
    h_req = 1'b1; h_we = 1'b1;
    for (int i = 0; i < 8; i++) begin
      h_addr = AW'(14'h100 + i);
      h_wdata = DW'(8'h11 * (i + 1));
      cycle();
    end
    set_idle();
    cycle();
    prio_run(3);

    // Host write to the top address, then a display read of it right behind.
    h_req = 1'b1; h_we = 1'b1; h_addr = 14'h3FFF; h_wdata = 6'h3F;
    cycle();
    check("wr_ram_we", ram_we, 1);
    check("wr_ram_addr", ram_addr, 14'h3FFF);
    set_idle();
    d_req = 1'b1; d_addr = 14'h3FFF;
    cycle();
    set_idle();
    repeat (3) cycle();
    check("d_rdata_3f", d_rdata, 6'h3F);

    // Reset one cycle after a display read accept: the read must never return.
    d_req = 1'b1; d_addr = 14'h0105;
    cycle();
    set_idle();
    cycle();
    reset_pulse();
    repeat (4) cycle();
    check("post_rst_hg", host_grants, 0);
    prio_run(2);

    // Host grant counter wrap.
    cycle();
    reset_pulse();
    h_req = 1'b1; h_we = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      h_addr = AW'($urandom_range(0, (1 << AW) - 1));
      h_wdata = DW'($urandom);
      cycle();
    end
    check("hg_ffff", host_grants, 16'hFFFF);
    cycle();
    check("hg_wrap", host_grants, 16'h0000);
    set_idle();
    repeat (3) cycle();

    // Randomized traffic; a denied requester keeps its request stable.
    for (int i = 0; i < 3000; i++) begin
      if (!(h_req && !obs_hg)) begin
        h_req   = ($urandom_range(0, 2) != 0);
        h_we    = $urandom_range(0, 1) == 1;
        h_addr  = AW'($urandom_range(0, 63));
        h_wdata = DW'($urandom);
      end
      if (!(d_req && !obs_dg)) begin
        d_req  = $urandom_range(0, 1) == 1;
        d_addr = AW'($urandom_range(0, 63));
      end
      cycle();
    end
    set_idle();
    repeat (4) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
